// File: rtl/usb_pkg.sv
// Shared types for the USB receive path: RX stage packet codes and RX buffer FSM states.
package usb_pkg;

  typedef enum logic [2:0] {
    RX_NONE = 3'd0,
    RX_DATA = 3'd1,
    RX_EOP  = 3'd2,
    RX_ERR  = 3'd3
  } rx_packet_e;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } rx_state_e;

endpackage

// File: rtl/rx_buf_mem.sv
// Byte storage for the RX buffer: synchronous write port, combinational (show-ahead) read port.
module rx_buf_mem #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_rx_buffer.sv
// Packet-aware RX FIFO: bytes are written speculatively and only become readable on a clean EOP.
// Optional USB_RX_CRC_STRIP_EN drops the trailing CRC16 bytes of each committed packet.
module usb_rx_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          store_rx_packet_i,
  input  logic [2:0]    rx_packet_i,
  input  logic [7:0]    rx_packet_data_i,
  input  logic          get_rx_data_i,
  input  logic          flush_i,
  output logic [7:0]    rx_data_o,
  output logic [PW-1:0] buffer_occupancy_o,
  output logic          buffer_empty_o,
  output logic          buffer_full_o,
  output logic          overflow_o,
  output logic          pkt_done_o,
  output logic          pkt_dropped_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_state_e     state_q, state_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          dropped_q, dropped_d;

  logic [PW-1:0] occupancy;
  logic [PW-1:0] stored;
  logic          empty;
  logic          full;
  logic          mem_we;
  logic [7:0]    mem_rdata;

  assign occupancy = cptr_q - rptr_q;
  assign stored    = wptr_q - rptr_q;
  assign empty     = (occupancy == '0);
  assign full      = (stored == PW'(DEPTH));

`ifdef USB_RX_CRC_STRIP_EN
  logic [PW-1:0] pkt_len;
  assign pkt_len = wptr_q - cptr_q;
`endif

  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    cptr_d     = cptr_q;
    wptr_d     = wptr_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;
    mem_we     = 1'b0;

    if (flush_i) begin
      state_d    = StIdle;
      rptr_d     = '0;
      cptr_d     = '0;
      wptr_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (get_rx_data_i && !empty) begin
        rptr_d = rptr_q + PW'(1);
      end

      if (store_rx_packet_i) begin
        case (state_q)
          StIdle, StRecv: begin
            if (rx_packet_i == RX_DATA) begin
              // Fullness counts speculative bytes; a same-cycle pop does not make room yet.
              if (full) begin
                overflow_d = 1'b1;
                wptr_d     = cptr_q;
                state_d    = StDrop;
              end else begin
                mem_we  = 1'b1;
                wptr_d  = wptr_q + PW'(1);
                state_d = StRecv;
              end
            end else if (state_q == StRecv && rx_packet_i == RX_EOP) begin
              state_d = StIdle;
`ifdef USB_RX_CRC_STRIP_EN
              if (pkt_len < PW'(2)) begin
                wptr_d    = cptr_q;
                dropped_d = 1'b1;
              end else begin
                cptr_d = wptr_q - PW'(2);
                wptr_d = wptr_q - PW'(2);
                done_d = 1'b1;
              end
`else
              cptr_d = wptr_q;
              done_d = 1'b1;
`endif
            end else if (state_q == StRecv && rx_packet_i == RX_ERR) begin
              wptr_d    = cptr_q;
              dropped_d = 1'b1;
              state_d   = StIdle;
            end
          end
          StDrop: begin
            if (rx_packet_i == RX_EOP || rx_packet_i == RX_ERR) begin
              dropped_d = 1'b1;
              state_d   = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rptr_q     <= '0;
      cptr_q     <= '0;
      wptr_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rptr_q     <= rptr_d;
      cptr_q     <= cptr_d;
      wptr_q     <= wptr_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

  rx_buf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (rx_packet_data_i),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Head byte is forced to zero while nothing is committed so reset reads back 8'h00.
  assign rx_data_o          = empty ? 8'h00 : mem_rdata;
  assign buffer_occupancy_o = occupancy;
  assign buffer_empty_o     = empty;
  assign buffer_full_o      = full;
  assign overflow_o         = overflow_q;
  assign pkt_done_o         = done_q;
  assign pkt_dropped_o      = dropped_q;

endmodule

// File: tb/tb_usb_rx_buffer.sv
// Directed self-checking bench for usb_rx_buffer (DEPTH=64).
module tb_usb_rx_buffer;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  localparam logic [2:0] CNone = 3'd0;
  localparam logic [2:0] CData = 3'd1;
  localparam logic [2:0] CEop  = 3'd2;
  localparam logic [2:0] CErr  = 3'd3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          store_rx_packet_i = 1'b0;
  logic [2:0]    rx_packet_i = 3'd0;
  logic [7:0]    rx_packet_data_i = 8'h00;
  logic          get_rx_data_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [7:0]    rx_data_o;
  logic [PW-1:0] buffer_occupancy_o;
  logic          buffer_empty_o;
  logic          buffer_full_o;
  logic          overflow_o;
  logic          pkt_done_o;
  logic          pkt_dropped_o;

  int n_checks = 0;
  int n_errors = 0;

  usb_rx_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .store_rx_packet_i  (store_rx_packet_i),
    .rx_packet_i        (rx_packet_i),
    .rx_packet_data_i   (rx_packet_data_i),
    .get_rx_data_i      (get_rx_data_i),
    .flush_i            (flush_i),
    .rx_data_o          (rx_data_o),
    .buffer_occupancy_o (buffer_occupancy_o),
    .buffer_empty_o     (buffer_empty_o),
    .buffer_full_o      (buffer_full_o),
    .overflow_o         (overflow_o),
    .pkt_done_o         (pkt_done_o),
    .pkt_dropped_o      (pkt_dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after an edge; outputs are inspected 1ns after the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [2:0] code, input logic [7:0] data);
    store_rx_packet_i = 1'b1;
    rx_packet_i       = code;
    rx_packet_data_i  = data;
    tick();
    store_rx_packet_i = 1'b0;
    rx_packet_i       = CNone;
  endtask

  task automatic pop();
    get_rx_data_i = 1'b1;
    tick();
    get_rx_data_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_data"}, 32'(rx_data_o), 32'h00);
    check({tag, " occupancy"}, 32'(buffer_occupancy_o), 32'd0);
    check({tag, " empty"}, 32'(buffer_empty_o), 32'd1);
    check({tag, " full"}, 32'(buffer_full_o), 32'd0);
    check({tag, " overflow"}, 32'(overflow_o), 32'd0);
    check({tag, " pkt_done"}, 32'(pkt_done_o), 32'd0);
    check({tag, " pkt_dropped"}, 32'(pkt_dropped_o), 32'd0);
  endtask

  initial begin
    logic [7:0] vec3 [3];
    vec3[0] = 8'hA1;
    vec3[1] = 8'hB2;
    vec3[2] = 8'hC3;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();

`ifdef USB_RX_CRC_STRIP_EN
    for (int i = 0; i < 4; i++) send(CData, 8'(8'h40 + i));
    send(CEop, 8'h00);
    check("crc4 occupancy", 32'(buffer_occupancy_o), 32'd2);
    check("crc4 done", 32'(pkt_done_o), 32'd1);
    check("crc4 head", 32'(rx_data_o), 32'h40);
    pop();
    check("crc4 second", 32'(rx_data_o), 32'h41);
    pop();
    check("crc4 empty", 32'(buffer_empty_o), 32'd1);
    send(CData, 8'h77);
    send(CEop, 8'h00);
    check("crc1 dropped", 32'(pkt_dropped_o), 32'd1);
    check("crc1 done", 32'(pkt_done_o), 32'd0);
    check("crc1 occupancy", 32'(buffer_occupancy_o), 32'd0);
    for (int i = 0; i < 3; i++) send(CData, 8'(8'h50 + i));
    send(CEop, 8'h00);
    check("crc3 occupancy", 32'(buffer_occupancy_o), 32'd1);
    check("crc3 head", 32'(rx_data_o), 32'h50);
`else
    // Speculative bytes stay invisible until EOP.
    for (int i = 0; i < 3; i++) send(CData, vec3[i]);
    check("spec occupancy", 32'(buffer_occupancy_o), 32'd0);
    check("spec empty", 32'(buffer_empty_o), 32'd1);
    send(CEop, 8'h00);
    check("commit occupancy", 32'(buffer_occupancy_o), 32'd3);
    check("commit head", 32'(rx_data_o), 32'hA1);
    check("commit done", 32'(pkt_done_o), 32'd1);
    tick();
    check("done one-shot", 32'(pkt_done_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pop%0d data", i), 32'(rx_data_o), 32'(vec3[i]));
      pop();
    end
    check("drained empty", 32'(buffer_empty_o), 32'd1);
    pop();
    check("pop on empty", 32'(buffer_occupancy_o), 32'd0);

    // Rollback on RX_ERR, then a clean packet.
    for (int i = 0; i < 5; i++) send(CData, 8'(8'h90 + i));
    send(CErr, 8'h00);
    check("err dropped", 32'(pkt_dropped_o), 32'd1);
    check("err occupancy", 32'(buffer_occupancy_o), 32'd0);
    send(3'd6, 8'hEE);
    send(CData, 8'h11);
    send(CData, 8'h22);
    send(CEop, 8'h00);
    check("after err occupancy", 32'(buffer_occupancy_o), 32'd2);
    check("after err head", 32'(rx_data_o), 32'h11);
    pop();
    check("after err second", 32'(rx_data_o), 32'h22);
    pop();

    // Overflow: 64 bytes fill the buffer, the 65th is dropped.
    for (int i = 0; i < 64; i++) send(CData, 8'(i));
    check("fill full", 32'(buffer_full_o), 32'd1);
    check("fill occupancy", 32'(buffer_occupancy_o), 32'd0);
    send(CData, 8'hFF);
    check("ovf flag", 32'(overflow_o), 32'd1);
    check("ovf rollback full", 32'(buffer_full_o), 32'd0);
    send(CData, 8'hFE);
    send(CEop, 8'h00);
    check("ovf dropped", 32'(pkt_dropped_o), 32'd1);
    check("ovf done", 32'(pkt_done_o), 32'd0);
    check("ovf occupancy", 32'(buffer_occupancy_o), 32'd0);
    tick();
    check("ovf sticky", 32'(overflow_o), 32'd1);
    do_flush();
    check("flush clears ovf", 32'(overflow_o), 32'd0);

    // Interleave with pointer wrap.
    for (int i = 0; i < 60; i++) send(CData, 8'(i));
    send(CEop, 8'h00);
    check("wrap commit60", 32'(buffer_occupancy_o), 32'd60);
    for (int i = 0; i < 10; i++) pop();
    check("wrap after pops", 32'(buffer_occupancy_o), 32'd50);
    for (int i = 0; i < 12; i++) send(CData, 8'(8'h64 + i));
    send(CEop, 8'h00);
    check("wrap occupancy", 32'(buffer_occupancy_o), 32'd62);
    for (int i = 0; i < 62; i++) begin
      logic [7:0] exp;
      exp = (i < 50) ? 8'(10 + i) : 8'(8'h64 + i - 50);
      check($sformatf("wrap rd%0d", i), 32'(rx_data_o), 32'(exp));
      pop();
    end
    check("wrap drained", 32'(buffer_empty_o), 32'd1);

    // Flush beats a same-cycle write and pop.
    send(CData, 8'h55);
    send(CEop, 8'h00);
    send(CData, 8'h77);
    flush_i           = 1'b1;
    store_rx_packet_i = 1'b1;
    rx_packet_i       = CData;
    rx_packet_data_i  = 8'h99;
    get_rx_data_i     = 1'b1;
    tick();
    flush_i           = 1'b0;
    store_rx_packet_i = 1'b0;
    rx_packet_i       = CNone;
    get_rx_data_i     = 1'b0;
    check_reset_outputs("flush");
    check("flush rptr", 32'(dut.rptr_q), 32'd0);
    check("flush cptr", 32'(dut.cptr_q), 32'd0);
    check("flush wptr", 32'(dut.wptr_q), 32'd0);
    send(CEop, 8'h00);
    check("flush idle eop", 32'(pkt_done_o), 32'd0);
    send(CData, 8'hAB);
    send(CEop, 8'h00);
    check("post flush occ", 32'(buffer_occupancy_o), 32'd1);
    check("post flush head", 32'(rx_data_o), 32'hAB);

    // Asynchronous reset mid-packet discards committed data too.
    send(CData, 8'hCD);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async rst");
    tick();
    rst_i = 1'b0;
    tick();
    send(CEop, 8'h00);
    check("rst idle eop done", 32'(pkt_done_o), 32'd0);
    check("rst idle eop occ", 32'(buffer_occupancy_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
